// File: rtl/dsp_seq_pkg.sv
// Shared types and OPMODE constants for the DSP slice MAC sequencer.
package dsp_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [7:0] OPM_MUL     = 8'h01;  // X=M, Z=0
  localparam logic [7:0] OPM_MAC     = 8'h09;  // X=M, Z=P
  localparam logic [7:0] OPM_OFF     = 8'h00;
  localparam int         OPM_SUB_BIT = 7;

  // OPMODE is only meaningful while the P register is enabled; park it at 0 otherwise.
  function automatic logic [7:0] opmode_sel(input logic ce_p, input logic first, input logic sub);
    logic [7:0] o;
    o = first ? OPM_MUL : OPM_MAC;
    o[OPM_SUB_BIT] = sub;
    return ce_p ? o : OPM_OFF;
  endfunction

endpackage

// File: rtl/dsp_seq_token_pipe.sv
// Two-stage valid/first token shift tracking operands through the A/B and M registers.
module dsp_seq_token_pipe (
  input  logic clk,
  input  logic Reset,
  input  logic flush,
  input  logic accept,
  input  logic first,
  output logic ce_m,
  output logic ce_p,
  output logic p_first
);

  logic v_ab, f_ab, v_m, f_m;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      v_ab <= 1'b0;
      f_ab <= 1'b0;
      v_m  <= 1'b0;
      f_m  <= 1'b0;
    end else if (flush) begin
      v_ab <= 1'b0;
      f_ab <= 1'b0;
      v_m  <= 1'b0;
      f_m  <= 1'b0;
    end else begin
      v_ab <= accept;
      f_ab <= accept & first;
      v_m  <= v_ab;
      f_m  <= f_ab;
    end
  end

  assign ce_m    = v_ab;
  assign ce_p    = v_m;
  assign p_first = f_m;

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Sequences a DSP48A1-style slice through an N-term multiply-accumulate.
// Build option: DSP_SEQ_SUBTRACT_EN adds a 'sub' input that turns the run into P = 0 - sum(M).
module dsp_mac_sequencer
  import dsp_seq_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
`ifdef DSP_SEQ_SUBTRACT_EN
  input  logic             sub,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ce_ab,
  output logic             ce_m,
  output logic             ce_p,
  output logic             rst_p,
  output logic [7:0]       opmode,
  output logic             busy,
  output logic             done,
  output logic [2:0]       dbg_state
);

  // Handshake: an operand pair transfers in any cycle where in_valid and in_ready
  // are both high; in_ready depends only on state and abort, never on in_valid.

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] count;
  logic [LEN_W-1:0] count_nxt;
  logic             sub_q;
  logic             accept;
  logic             p_first;

  assign in_ready  = (state == S_FEED) & ~abort;
  assign accept    = in_ready & in_valid;
  assign ce_ab     = accept;
  assign count_nxt = count + LEN_W'(1);

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
      len_q <= '0;
      count <= '0;
    end else if (abort) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q <= len;
            count <= '0;
            state <= S_CLEAR;
          end
        end
        S_CLEAR: state <= (len_q != '0) ? S_FEED : S_DONE;
        S_FEED: begin
          if (accept) begin
            count <= count_nxt;
            if (count_nxt == len_q) state <= S_DRAIN;
          end
        end
        // Once the A/B stage is empty, the last P update happens this cycle.
        S_DRAIN: if (!ce_m) state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DSP_SEQ_SUBTRACT_EN
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      sub_q <= 1'b0;
    end else if (!abort && state == S_IDLE && start) begin
      sub_q <= sub;
    end
  end
`else
  assign sub_q = 1'b0;
`endif

  dsp_seq_token_pipe u_pipe (
    .clk     (clk),
    .Reset   (Reset),
    .flush   (abort),
    .accept  (accept),
    .first   (count == '0),
    .ce_m    (ce_m),
    .ce_p    (ce_p),
    .p_first (p_first)
  );

  assign opmode    = opmode_sel(ce_p, p_first, sub_q);
  assign rst_p     = (state == S_CLEAR);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: vector table plus hand sequences, driving a behavioural DSP slice.
module tb_dsp_mac_sequencer;
  import dsp_seq_pkg::*;

  logic       clk, Reset, start, abort, in_valid, sub_i;
  logic [7:0] len_i;
  logic       in_ready, ce_ab, ce_m, ce_p, rst_p, busy, done;
  logic [7:0] opmode;
  logic [2:0] dbg_state;

  logic signed [17:0] a_in, b_in, a_r, b_r;
  logic signed [47:0] m_r, p_r;

  int checks = 0;
  int errors = 0;
  int ab_cnt, p_cnt, rst_cnt;
  logic [7:0] exp_q[$];

  dsp_mac_sequencer #(.LEN_W(8)) dut (
    .clk       (clk),
    .Reset     (Reset),
    .start     (start),
    .len       (len_i),
    .abort     (abort),
`ifdef DSP_SEQ_SUBTRACT_EN
    .sub       (sub_i),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ce_ab     (ce_ab),
    .ce_m      (ce_m),
    .ce_p      (ce_p),
    .rst_p     (rst_p),
    .opmode    (opmode),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural slice: A/B -> M -> P with OPMODE-selected Z and post-adder subtract.
  always @(posedge clk) begin
    if (ce_ab) begin
      a_r <= a_in;
      b_r <= b_in;
    end
    if (ce_m) m_r <= 48'(a_r * b_r);
    if (rst_p) p_r <= '0;
    else if (ce_p) begin
      if (opmode[7])
        p_r <= ((opmode[3:2] == 2'b10) ? p_r : 48'sd0) - ((opmode[1:0] == 2'b01) ? m_r : 48'sd0);
      else
        p_r <= ((opmode[3:2] == 2'b10) ? p_r : 48'sd0) + ((opmode[1:0] == 2'b01) ? m_r : 48'sd0);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_opm(input bit first, input logic subv);
    logic [7:0] o;
    o = first ? 8'h01 : 8'h09;
    if (subv) o = o | 8'h80;
    return o;
  endfunction

  // Scoreboard: each accept queues the OPMODE its P update must carry.
  always @(negedge clk) begin
    if (!Reset) begin
      if (ce_ab) ab_cnt++;
      if (rst_p) rst_cnt++;
      if (ce_p) begin
        p_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ce_p_unexpected: got ce_p=1 opmode %0h expected no P update", opmode);
        end else begin
          chk("opmode", {56'd0, opmode}, {56'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic set_ops(input int opsel, input int idx);
    if (opsel == 0) begin
      a_in = 18'(idx + 1);
      b_in = 18'(idx + 1);
    end else begin
      a_in = (idx == 0) ? 18'sd5 : 18'sd7;
      b_in = 18'sd1;
    end
  endtask

  // mode: 0 = in_valid held high, 1 = bubble every other FEED cycle, 2 = random.
  task automatic run_mac(input int L, input int mode, input int opsel, input logic subv,
                         input int exp_cyc, input longint exp_p, input int glitch);
    int c, idx;
    bit got_done, ph;
    ab_cnt = 0; p_cnt = 0; rst_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; len_i = 8'(L); sub_i = subv;
    c = 0; idx = 0; got_done = 0; ph = 0;
    while (!got_done && c < 2000) begin
      @(posedge clk); #1;
      c++;
      start = (c == glitch);
      in_valid = 1'b0;
      if (in_ready && idx < L) begin
        case (mode)
          0:       in_valid = 1'b1;
          1:       in_valid = ~ph;
          default: in_valid = 1'($urandom_range(0, 1));
        endcase
        ph = ~ph;
        set_ops(opsel, idx);
        if (in_valid) exp_q.push_back(exp_opm(idx == 0, subv));
      end
      #1;
      if (in_valid && in_ready) idx++;
      if (done) got_done = 1;
    end
    in_valid = 1'b0;
    start = 1'b0;
    chk("done_seen", {63'd0, got_done}, 64'd1);
    if (exp_cyc > 0) chk("done_cycle", 64'(c), 64'(exp_cyc));
    chk("p_final", 64'(p_r), 64'(exp_p));
    chk("ce_ab_count", 64'(ab_cnt), 64'(L));
    chk("ce_p_count", 64'(p_cnt), 64'(L));
    chk("rst_p_count", 64'(rst_cnt), 64'd1);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #2;
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    chk("idle_after_done", {63'd0, busy}, 64'd0);
  endtask

  typedef struct {
    int     len;
    int     mode;
    int     glitch;
    int     exp_cyc;
    longint exp_p;
  } vec_t;

  vec_t vecs[7];

  initial begin
    Reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; sub_i = 1'b0;
    len_i = '0; a_in = '0; b_in = '0;
    ab_cnt = 0; p_cnt = 0; rst_cnt = 0;

    vecs[0] = '{len: 4,   mode: 0, glitch: 0, exp_cyc: 8,   exp_p: 30};
    vecs[1] = '{len: 3,   mode: 1, glitch: 0, exp_cyc: 9,   exp_p: 14};
    vecs[2] = '{len: 0,   mode: 0, glitch: 0, exp_cyc: 2,   exp_p: 0};
    vecs[3] = '{len: 1,   mode: 0, glitch: 0, exp_cyc: 5,   exp_p: 1};
    vecs[4] = '{len: 4,   mode: 0, glitch: 3, exp_cyc: 8,   exp_p: 30};
    vecs[5] = '{len: 6,   mode: 2, glitch: 0, exp_cyc: 0,   exp_p: 91};
    vecs[6] = '{len: 255, mode: 0, glitch: 0, exp_cyc: 259, exp_p: 5559680};

    #12;
    chk("rst_outputs", {52'd0, in_ready, ce_ab, ce_m, ce_p, rst_p, busy, done, dbg_state, 1'b0},
        64'd0);
    chk("rst_opmode", {56'd0, opmode}, 64'd0);
    @(posedge clk); #1;
    Reset = 1'b0;

    for (int i = 0; i < 7; i++)
      run_mac(vecs[i].len, vecs[i].mode, 0, 1'b0, vecs[i].exp_cyc, vecs[i].exp_p, vecs[i].glitch);

`ifdef DSP_SEQ_SUBTRACT_EN
    run_mac(2, 0, 1, 1'b1, 6, -12, 0);
`endif

    // start and abort together in IDLE: abort wins
    @(posedge clk); #1;
    start = 1'b1; len_i = 8'd3; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle_busy", {63'd0, busy}, 64'd0);
    chk("start_abort_idle_rst_p", {63'd0, rst_p}, 64'd0);
    @(posedge clk); #1;
    chk("start_abort_idle_stays", {63'd0, busy}, 64'd0);

    // abort while draining
    @(posedge clk); #1;
    start = 1'b1; len_i = 8'd2;
    @(posedge clk); #1;
    start = 1'b0;
    chk("abort_seq_clear", {63'd0, rst_p}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b1; a_in = 18'sd3; b_in = 18'sd3;
    exp_q.push_back(exp_opm(1, 1'b0));
    @(posedge clk); #1;
    a_in = 18'sd4; b_in = 18'sd4;
    exp_q.push_back(exp_opm(0, 1'b0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("abort_seq_in_drain", 64'(dbg_state), 64'(S_DRAIN));
    chk("abort_seq_drain_ready", {63'd0, in_ready}, 64'd0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_outputs", {57'd0, busy, done, ce_ab, ce_m, ce_p, rst_p, in_ready}, 64'd0);
    chk("abort_opmode", {56'd0, opmode}, 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("abort_no_done", {62'd0, done, busy}, 64'd0);
    end
    exp_q.delete();

    // asynchronous reset in the middle of FEED, then a clean run
    @(posedge clk); #1;
    start = 1'b1; len_i = 8'd4;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; set_ops(0, k);
      exp_q.push_back(exp_opm(k == 0, 1'b0));
    end
    #1;
    Reset = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("midrun_reset_outputs",
        {54'd0, in_ready, ce_ab, ce_m, ce_p, rst_p, busy, done, dbg_state}, 64'd0);
    chk("midrun_reset_opmode", {56'd0, opmode}, 64'd0);
    @(posedge clk); #1;
    Reset = 1'b0;
    exp_q.delete();
    run_mac(4, 0, 0, 1'b0, 8, 30, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsp_mac_sequencer.md
# dsp_mac_sequencer

Controller that sequences the DSP48A1-style multiply/post-add slice through an N-term multiply-accumulate. It accepts a length on `start` and pulls operand pairs over a valid/ready handshake. It drives the slice's clock enables, P-register reset and OPMODE so each accepted pair walks A/B reg → M reg → P reg. It pulses `done` when the final sum is stable in P. It sits between the sample-fetch logic and the DSP slice, and is the only driver of the slice's CE/OPMODE pins.

## Interface
- `LEN_W`, 8, width of the term-count input and internal counter.

- `clk`  in  1  clock
- `Reset`  in  1  reset, asynchronous, active-high
- `start`  in  1  begin a MAC run; sampled only in IDLE
- `len`  in  LEN_W  number of products to accumulate; latched with `start`
- `abort`  in  1  synchronous cancel of the current run
- `in_valid`  in  1  upstream A/B operand pair valid
- `in_ready`  out  1  sequencer will accept the pair this cycle
- `ce_ab`  out  1  clock enable for slice A/B input registers
- `ce_m`  out  1  clock enable for slice M register
- `ce_p`  out  1  clock enable for slice P register
- `rst_p`  out  1  synchronous reset to slice P register
- `opmode`  out  8  slice OPMODE
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse when P holds the final sum

## Operation
- FSM states: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE:
  - `start`=1 latches `len` and goes to CLEAR.
  - `start` is ignored in every other state.
- CLEAR: `rst_p`=1 for exactly one cycle.
  - Next state is FEED if latched len≠0, otherwise DONE.
- FEED: `in_ready`=1.
  - Accept means `in_valid & in_ready`. On accept, `ce_ab`=1 (combinational) and the counter increments.
  - On the accept that makes count==len, go to DRAIN.
- Token pipe: two flag registers, `v_ab` and `v_m`. Each carries a `first` bit, set on the first accept after CLEAR.
  - `v_ab` is set on the cycle following an accept.
  - `v_m` <= `v_ab`.
  - `ce_m` = `v_ab`, `ce_p` = `v_m`.
  - A bubble (`in_valid`=0) produces no token, so A/B/M/P hold their values.
- `opmode`: `8'h01` (X=M, Z=0) when `ce_p` and the token is first. `8'h09` (X=M, Z=P) when `ce_p` and the token is not first. `8'h00` otherwise.
- DRAIN: `in_ready`=0. Go to DONE when `v_ab`==0, since the last P update occurs this cycle.
- DONE: `done`=1 for one cycle, then IDLE.
- `abort`:
  - Highest priority after Reset.
  - Next cycle: state IDLE, tokens cleared, all enables 0.
  - `done` is not pulsed.
  - P contents are undefined.
- Reset (any time, including mid-run): state IDLE, counter 0, tokens 0, every output 0.

## Timing
- Reset value of every output is 0. `opmode`=`8'h00`.
- An accept in cycle t produces `ce_m` in t+1, and `ce_p` with a valid `opmode` in t+2. P is valid after the t+2 edge.
- Last accept at t gives DRAIN in t+1..t+2 and `done` in t+3.
- len=1 with `in_valid` held high from the start:
  - `start` at t0, `rst_p` at t1, accept at t2, `done` at t5.
- len=0: `start` at t0, `rst_p` at t1, `done` at t2. P=0.
- Counter is LEN_W bits. len=2^LEN_W−1 completes without wrap.
- `start` and `abort` in the same cycle in IDLE: abort wins and the state stays IDLE.

## Configuration
- `DSP_SEQ_SUBTRACT_EN` defined:
  - Adds input port `sub`, 1 bit, latched with `start`.
  - When latched `sub`=1, `opmode[7]`=1 on every `ce_p` cycle, so the run yields P = 0 − ΣM.
- `DSP_SEQ_SUBTRACT_EN` undefined: no `sub` port, and `opmode[7]` is constant 0.

## Structure
- Package `dsp_seq_pkg`:
  - state enum
  - `OPM_MUL`=`8'h01`
  - `OPM_MAC`=`8'h09`
  - `OPM_SUB_BIT`=7
- Sub-module `dsp_seq_token_pipe`: the 2-stage valid/first shift, with outputs `ce_m`, `ce_p`, `p_first`.

## Test plan
- len=4, `in_valid` held high, operands A=B=1..4 → four accepts on consecutive cycles. `opmode` sequence is 01,09,09,09 on `ce_p`. `done` 3 cycles after the last accept. P=30.
- len=3 with `in_valid` low every other cycle → `ce_m`/`ce_p` gaps mirror the bubbles. P=Σ, with no extra accumulation.
- len=0 → `rst_p` one cycle, `done` 2 cycles after `start`. No `ce_ab`. P=0.
- `start` pulsed during FEED → ignored, count unchanged. `abort` in DRAIN → IDLE next cycle, no `done`, all CE=0.
- Reset asserted mid-FEED → all outputs 0 immediately. A new `start` after release completes normally.
- With `DSP_SEQ_SUBTRACT_EN`, `sub`=1, len=2, products 5 and 7 → `opmode` 81, 89. P=−12.
